mul32_seq_core: RTL
===================

MUL32_SEQ_CORE -- requirements
Module: mul32_seq_core

Interface
REQ-001 SHALL have a single clock `clk` and an asynchronous, active-high reset `rst`.
REQ-002 SHALL expose ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a multiply.
- mc  input  32  multiplicand, unsigned.
- mp  input  32  multiplier, unsigned.
- p  output  64  product register.
- done  output  1  result valid, level signal.
- busy  output  1  multiply in progress.
REQ-003 SHALL have no parameters; all widths are fixed at 32x32->64.

Function
REQ-004 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-005 SHALL sample `mc` and `mp` into internal registers on the rising edge where `start`=1 and the state is IDLE or DONE; `mc`/`mp` are don't-care at all other times.
REQ-006 SHALL, on that capture edge, clear the 64-bit accumulator and 6-bit iteration counter, deassert `done`, assert `busy`, and enter BUSY.
REQ-007 SHALL perform one radix-2 shift-add step per clock while in BUSY:
- if the multiplier LSB is 1, add the captured `mc` into accumulator bits [63:32] using a 33-bit sum;
- shift the 33-bit sum concatenated with accumulator bits [31:0] right by one;
- shift the multiplier register right by one.
REQ-008 SHALL complete after exactly 32 BUSY steps: `done`=1, `busy`=0, `p` loaded with the final accumulator, state DONE. If the capture edge is N, `done` first reads 1 after edge N+32.
REQ-009 SHALL update `p` only at completion; `p` holds the previous result during BUSY and never shows partial sums.
REQ-010 SHALL hold `done`=1 and `p` stable in DONE indefinitely until the next accepted `start` or reset.
REQ-011 SHALL ignore `start` while BUSY: no recapture, no counter change, and the latency of the running operation is unchanged.
REQ-012 SHALL accept `start` in DONE as in IDLE, deassert `done` on that edge, and keep `p` at the old value until the new result loads.
REQ-013 SHALL produce exact unsigned results for all operands, including 0 and 0xFFFFFFFF, with no overflow: the maximum product 0xFFFFFFFE00000001 fits in 64 bits.
REQ-014 SHALL drive `busy`=1 exactly in BUSY and `done`=1 exactly in DONE; both are never high together.
REQ-015 SHALL drive all outputs directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-016 SHALL, while `rst`=1 and regardless of `clk`, force state IDLE, `p`=64'h0, `done`=0, `busy`=0, and clear the accumulator, counter and operand registers.
REQ-017 SHALL abort any in-flight operation when reset is asserted mid-BUSY; no result is delivered afterwards.
REQ-018 SHALL accept a `start` on the first rising edge after `rst` deasserts.

Verification
REQ-019 Basic: reset, then `start` with mc=3, mp=5 -> `busy`=1 for 32 cycles; `done`=1 after edge N+32; p=64'h000000000000000F.
REQ-020 Extremes: mc=mp=0xFFFFFFFF -> p=64'hFFFFFFFE00000001. Also mc=0x12345678, mp=0 -> p=0 with `done` still at N+32.
REQ-021 Busy-ignore: mc=7, mp=9 started; at step 10 pulse `start` with mc=mp=0xFFFFFFFF -> p=64'd63 at the original N+32; no second completion follows.
REQ-022 Back-to-back: first result 2*3=6 in DONE; `start` with mc=0x10000, mp=0x10000 -> `done` drops on that edge; p reads 6 throughout BUSY; then p=64'h0000000100000000.
REQ-023 Reset mid-op: assert `rst` at step 15 of mc=mp=0xFFFF -> p=0, `done`=0, `busy`=0 immediately; after release a new `start` with mc=2, mp=2 gives p=4.
REQ-024 Random: at least 10,000 random unsigned operand pairs checked against a 64-bit reference product, each with latency exactly 32 cycles.

Source files
------------

// File: rtl/mul32_seq_core.sv
// mul32_seq_core: sequential 32x32 -> 64 unsigned multiplier, radix-2
// shift-add, one step per clock, 32 steps per product.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous active-high reset
//   start  in   1   request a multiply (accepted in IDLE or DONE)
//   mc     in  32   multiplicand, unsigned (sampled on accepted start)
//   mp     in  32   multiplier, unsigned (sampled on accepted start)
//   p      out 64   product register, updated only at completion
//   done   out  1   result valid, held until the next accepted start
//   busy   out  1   multiply in progress
module mul32_seq_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] mc,
  input  logic [31:0] mp,
  output logic [63:0] p,
  output logic        done,
  output logic        busy
);

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_mc;
  logic [W-1:0]    r_mp;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_p;
  logic            r_done;
  logic            r_busy;

  logic [W:0]      w_addend;
  logic [W:0]      w_sum;
  logic [PW-1:0]   w_acc_next;
  logic            w_last;

  // One shift-add step: 33-bit sum keeps the carry, which shifts into bit 63.
  assign w_addend   = r_mp[0] ? {1'b0, r_mc} : '0;
  assign w_sum      = {1'b0, r_acc[PW-1:W]} + w_addend;
  assign w_acc_next = {w_sum, r_acc[W-1:1]};
  assign w_last     = (r_cnt == CW'(W - 1));

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mc    <= '0;
      r_mp    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mc    <= mc;
            r_mp    <= mp;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_next;
          r_mp  <= r_mp >> 1;
          r_cnt <= r_cnt + CW'(1);
          // 32nd step: publish the full product; p never shows partial sums.
          if (w_last) begin
            r_p     <= w_acc_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign p    = r_p;
  assign done = r_done;
  assign busy = r_busy;

endmodule
